// File: rtl/bitrev_reorder_stream.sv
// Two-bank ping-pong buffer that turns bit-reversed FFT output into natural order with output backpressure.
// Optional macro BITREV_RUNTIME_SIZE_EN: per-frame size from cfg_bits (clamped); otherwise every frame is 2^MAX_BITS.
module bitrev_reorder_stream #(
    parameter int MAX_BITS = 10,
    parameter int MIN_BITS = 3,
    parameter int WIDTH    = 16,
    parameter int CW       = $clog2(MAX_BITS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CW-1:0]    cfg_bits,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             di_ready,
    output logic             do_en,
    input  logic             do_ready,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             do_sof,
    output logic             do_eof,
    output logic             ovf
);
    localparam int DEPTH = 1 << MAX_BITS;

    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING} bank_st_e;

    bank_st_e            state_q [2];
    bank_st_e            state_d [2];
    logic                wb_q, wb_d, rb_q, rb_d;
    logic [MAX_BITS-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                di_ready_q, di_ready_d;
    logic                do_en_q, do_en_d, do_sof_q, do_sof_d, do_eof_q, do_eof_d;
    logic                ovf_q, ovf_d;
    logic [WIDTH-1:0]    do_re_q, do_im_q;

    logic [WIDTH-1:0]    mem_re [2*DEPTH];
    logic [WIDTH-1:0]    mem_im [2*DEPTH];

    logic [CW-1:0]       wr_bits, rd_bits;
    logic [MAX_BITS-1:0] wr_rev, wr_addr;
    logic                wr_acc, wr_last, rd_avail, rd_load, rd_last;

    function automatic logic [MAX_BITS-1:0] last_idx(input logic [CW-1:0] b);
        logic [MAX_BITS:0] t;
        t = (MAX_BITS+1)'(1) << b;
        t = t - (MAX_BITS+1)'(1);
        return t[MAX_BITS-1:0];
    endfunction

`ifdef BITREV_RUNTIME_SIZE_EN
    logic [CW-1:0] bits_q [2];
    logic [CW-1:0] bits_d [2];
    logic [CW-1:0] cfg_clamped;

    always_comb begin
        cfg_clamped = cfg_bits;
        if (cfg_bits < CW'(MIN_BITS))
            cfg_clamped = CW'(MIN_BITS);
        else if (cfg_bits > CW'(MAX_BITS))
            cfg_clamped = CW'(MAX_BITS);
    end

    // The size is latched by the first accept into an empty bank and held for the whole frame.
    assign wr_bits = (state_q[wb_q] == ST_EMPTY) ? cfg_clamped : bits_q[wb_q];
    assign rd_bits = bits_q[rb_q];

    genvar gb;
    generate
        for (gb = 0; gb < 2; gb++) begin : g_bits
            always_comb begin
                bits_d[gb] = bits_q[gb];
                if (wr_acc && (wb_q == 1'(gb)) && (state_q[gb] == ST_EMPTY))
                    bits_d[gb] = cfg_clamped;
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    bits_q[gb] <= CW'(MAX_BITS);
                else
                    bits_q[gb] <= bits_d[gb];
            end
        end
    endgenerate
`else
    logic unused_cfg;
    assign wr_bits    = CW'(MAX_BITS);
    assign rd_bits    = CW'(MAX_BITS);
    assign unused_cfg = (^cfg_bits) ^ (MIN_BITS > MAX_BITS);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BITS; gi++) begin : g_rev
            assign wr_rev[gi] = wr_cnt_q[MAX_BITS-1-gi];
        end
    endgenerate

    // Reversing over MAX_BITS then shifting leaves the low wr_bits bits reversed.
    assign wr_addr  = wr_rev >> (CW'(MAX_BITS) - wr_bits);
    assign wr_acc   = di_en && di_ready_q;
    assign wr_last  = (wr_cnt_q == last_idx(wr_bits));
    assign rd_avail = (state_q[rb_q] == ST_FULL) || (state_q[rb_q] == ST_DRAINING);
    assign rd_load  = rd_avail && (!do_en_q || do_ready);
    assign rd_last  = (rd_cnt_q == last_idx(rd_bits));

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (wr_acc && (wb_q == 1'(b)))
                state_d[b] = wr_last ? ST_FULL : ST_FILLING;
            if (rd_load && (rb_q == 1'(b)))
                state_d[b] = rd_last ? ST_EMPTY : ST_DRAINING;
        end
        wb_d     = wb_q ^ (wr_acc && wr_last);
        rb_d     = rb_q ^ (rd_load && rd_last);
        wr_cnt_d = wr_cnt_q;
        if (wr_acc)
            wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
        rd_cnt_d = rd_cnt_q;
        if (rd_load)
            rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
    end

    always_comb begin
        di_ready_d = (state_d[wb_d] == ST_EMPTY) || (state_d[wb_d] == ST_FILLING);
        do_en_d    = do_en_q;
        do_sof_d   = do_sof_q;
        do_eof_d   = do_eof_q;
        if (rd_load) begin
            do_en_d  = 1'b1;
            do_sof_d = (rd_cnt_q == '0);
            do_eof_d = rd_last;
        end else if (do_ready) begin
            do_en_d  = 1'b0;
            do_sof_d = 1'b0;
            do_eof_d = 1'b0;
        end
        ovf_d = ovf_q || (di_en && !di_ready_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++)
                state_q[b] <= ST_EMPTY;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            di_ready_q <= 1'b1;
            do_en_q    <= 1'b0;
            do_sof_q   <= 1'b0;
            do_eof_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++)
                state_q[b] <= state_d[b];
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            di_ready_q <= di_ready_d;
            do_en_q    <= do_en_d;
            do_sof_q   <= do_sof_d;
            do_eof_q   <= do_eof_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_re[{wb_q, wr_addr}] <= di_re;
            mem_im[{wb_q, wr_addr}] <= di_im;
        end
    end

    // The RAM read register doubles as the output register, so it only advances on a load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            do_re_q <= '0;
            do_im_q <= '0;
        end else if (rd_load) begin
            do_re_q <= mem_re[{rb_q, rd_cnt_q}];
            do_im_q <= mem_im[{rb_q, rd_cnt_q}];
        end
    end

    assign di_ready = di_ready_q;
    assign do_en    = do_en_q;
    assign do_sof   = do_sof_q;
    assign do_eof   = do_eof_q;
    assign do_re    = do_re_q;
    assign do_im    = do_im_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_bitrev_reorder_stream.sv
// Bench for bitrev_reorder_stream: vector table, directed stall/reset sequences and a randomized scoreboard run.
module tb_bitrev_reorder_stream;
    localparam int MAXB = 3;
    localparam int MINB = 2;
    localparam int W    = 16;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int CW2  = $clog2(4 + 1);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CW-1:0] cfg_bits = '0;
    logic          di_en = 1'b0;
    logic [W-1:0]  di_re = '0, di_im = '0;
    logic          di_ready, do_en, do_sof, do_eof, ovf;
    logic          do_ready = 1'b1;
    logic [W-1:0]  do_re, do_im;

    logic [CW2-1:0] cfg2 = '0;
    logic           en2 = 1'b0;
    logic [W-1:0]   re2 = '0, im2 = '0;
    logic           di_ready2, do_en2, do_sof2, do_eof2, ovf2;
    logic [W-1:0]   do_re2, do_im2;

    always #5 clock = ~clock;

    bitrev_reorder_stream #(.MAX_BITS(MAXB), .MIN_BITS(MINB), .WIDTH(W)) u_dut (
        .clock(clock), .reset_n(reset_n), .cfg_bits(cfg_bits),
        .di_en(di_en), .di_re(di_re), .di_im(di_im), .di_ready(di_ready),
        .do_en(do_en), .do_ready(do_ready), .do_re(do_re), .do_im(do_im),
        .do_sof(do_sof), .do_eof(do_eof), .ovf(ovf)
    );

    bitrev_reorder_stream #(.MAX_BITS(4), .MIN_BITS(MINB), .WIDTH(W)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .cfg_bits(cfg2),
        .di_en(en2), .di_re(re2), .di_im(im2), .di_ready(di_ready2),
        .do_en(do_en2), .do_ready(1'b1), .do_re(do_re2), .do_im(do_im2),
        .do_sof(do_sof2), .do_eof(do_eof2), .ovf(ovf2)
    );

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic         en;
        logic [W-1:0] re;
        logic         x_en;
        logic [W-1:0] x_re;
        logic         x_sof;
        logic         x_eof;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    exp_t        exp_q[$];
    logic [31:0] cur_buf [8];
    int          cur_cnt = 0;
    int          cur_bits = MAXB;
    logic        exp_ovf = 1'b0;
    int          n_out = 0;
    int          out_first = -1;
    int          out_last = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic int rev(input int k, input int nb);
        int r = 0;
        for (int i = 0; i < nb; i++)
            if (k[i]) r = r | (1 << (nb - 1 - i));
        return r;
    endfunction

    // Reference: sample k of a bit-reversed frame belongs at natural index rev(k).
    task automatic model_accept(input logic [31:0] d, input int cfg);
        int   b;
        exp_t e;
        if (cur_cnt == 0) begin
            b = cfg;
            if (b < MINB) b = MINB;
            if (b > MAXB) b = MAXB;
`ifndef BITREV_RUNTIME_SIZE_EN
            b = MAXB;
`endif
            cur_bits = b;
        end
        cur_buf[rev(cur_cnt, cur_bits)] = d;
        cur_cnt++;
        if (cur_cnt == (1 << cur_bits)) begin
            for (int i = 0; i < cur_cnt; i++) begin
                e.sof  = (i == 0);
                e.eof  = (i == cur_cnt - 1);
                e.data = cur_buf[i];
                exp_q.push_back(e);
            end
            cur_cnt = 0;
        end
    endtask

    task automatic step();
        logic        acc, drop, oxf, stall, osof, oeof;
        logic [31:0] in_s, out_s;
        int          cfg;
        exp_t        e;
        acc   = di_en && di_ready;
        drop  = di_en && !di_ready;
        in_s  = {di_im, di_re};
        cfg   = int'(cfg_bits);
        oxf   = do_en && do_ready;
        stall = do_en && !do_ready;
        out_s = {do_im, do_re};
        osof  = do_sof;
        oeof  = do_eof;
        @(posedge clock);
        #1;
        cycle++;
        if (acc) model_accept(in_s, cfg);
        if (drop) exp_ovf = 1'b1;
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        if (oxf) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_output: got %0h required no output (cycle %0d)", out_s, cycle);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_s, e.data);
                chk("out_sof", 32'(osof), 32'(e.sof));
                chk("out_eof", 32'(oeof), 32'(e.eof));
            end
            n_out++;
            if (out_first < 0) out_first = cycle;
            out_last = cycle;
        end
        if (stall) begin
            chk("hold_en", 32'(do_en), 32'd1);
            chk("hold_data", {do_im, do_re}, out_s);
            chk("hold_flags", {30'd0, do_sof, do_eof}, {30'd0, osof, oeof});
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            di_en = 1'b1;
            di_re = W'($urandom);
            di_im = W'($urandom);
            step();
        end
        di_en = 1'b0;
    endtask

    task automatic drain(input int bound);
        int i = 0;
        di_en    = 1'b0;
        do_ready = 1'b1;
        while (exp_q.size() > 0 && i < bound) begin
            step();
            i++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        di_en   = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_do_en", 32'(do_en), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_flags", {30'd0, do_sof, do_eof}, 32'd0);
        chk("rst_di_ready", 32'(di_ready), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        cur_cnt = 0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        vec_t        tbl [18];
        int          seq8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int          n0, n2;
        logic [W-1:0] im_req;

        for (int t = 0; t < 18; t++) begin
            tbl[t].en    = (t < 8);
            tbl[t].re    = (t < 8) ? W'(seq8[t]) : '0;
            tbl[t].x_en  = (t >= 8) && (t <= 15);
            tbl[t].x_re  = (t >= 8) ? W'(t - 8) : '0;
            tbl[t].x_sof = (t == 8);
            tbl[t].x_eof = (t == 15);
        end

        cfg_bits = CW'(MAXB);
        repeat (3) @(posedge clock);
        #1;
        chk("reset_do_en", 32'(do_en), 32'd0);
        chk("reset_do_re", 32'(do_re), 32'd0);
        chk("reset_di_ready", 32'(di_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_ovf", 32'(ovf), 32'd0);

        // Single 8-point frame in bit-reversed order; row t holds values expected after edge t.
        do_ready = 1'b1;
        for (int t = 0; t < 18; t++) begin
            di_en = tbl[t].en;
            di_re = tbl[t].re;
            di_im = '0;
            step();
            chk("tv_do_en", 32'(do_en), 32'(tbl[t].x_en));
            chk("tv_sof", 32'(do_sof), 32'(tbl[t].x_sof));
            chk("tv_eof", 32'(do_eof), 32'(tbl[t].x_eof));
            if (tbl[t].x_en) chk("tv_do_re", 32'(do_re), 32'(tbl[t].x_re));
            chk("tv_di_ready", 32'(di_ready), 32'd1);
        end
        di_en = 1'b0;

        // Four frames back to back at full rate.
        out_first = -1;
        n0 = n_out;
        for (int i = 0; i < 32; i++) begin
            di_en = 1'b1;
            di_re = W'($urandom);
            di_im = W'($urandom);
            step();
            chk("b2b_di_ready", 32'(di_ready), 32'd1);
        end
        drain(40);
        chk("b2b_count", 32'(n_out - n0), 32'd32);
        chk("b2b_contig", 32'(out_last - out_first + 1), 32'd32);

        // Output stalled for 20 cycles while two frames arrive.
        n0 = n_out;
        do_ready = 1'b0;
        feed(16);
        chk("stall_di_ready", 32'(di_ready), 32'd0);
        feed(1);
        chk("stall_ovf", 32'(ovf), 32'd1);
        do_ready = 1'b0;
        repeat (3) step();
        drain(60);
        chk("stall_count", 32'(n_out - n0), 32'd16);

        // Reset mid-drain of one bank and mid-fill of the other, then a clean frame.
        do_ready = 1'b1;
        feed(11);
        chk("pre_rst_do_en", 32'(do_en), 32'd1);
        pulse_reset();
        cfg_bits = CW'(MAXB);
        n0 = n_out;
        feed(8);
        drain(30);
        chk("post_rst_count", 32'(n_out - n0), 32'd8);

        // Randomized traffic with random backpressure and random cfg_bits.
        for (int i = 0; i < 600; i++) begin
            di_en    = ($urandom_range(0, 3) != 0);
            di_re    = W'($urandom);
            di_im    = W'($urandom);
            do_ready = ($urandom_range(0, 2) != 0);
            cfg_bits = CW'($urandom);
            step();
        end
        drain(60);

`ifdef BITREV_RUNTIME_SIZE_EN
        // Runtime sizes: 8, 4 (cfg changed mid-frame), then a below-minimum request clamped to 4.
        pulse_reset();
        do_ready = 1'b1;
        n0 = n_out;
        cfg_bits = CW'(3);
        feed(8);
        cfg_bits = CW'(2);
        feed(2);
        cfg_bits = CW'(3);
        feed(2);
        cfg_bits = CW'(0);
        feed(4);
        drain(40);
        chk("rt_count", 32'(n_out - n0), 32'd16);
        cfg2 = CW2'(7);
`else
        cfg2 = CW2'(3);
`endif

        // 16-point instance: cfg_bits is either ignored or clamped up to the maximum size.
        chk("dut16_ready", 32'(di_ready2), 32'd1);
        n2 = 0;
        for (int c = 0; c < 48; c++) begin
            if (c < 16) begin
                en2 = 1'b1;
                re2 = W'(rev(c, 4));
                im2 = ~re2;
            end else begin
                en2 = 1'b0;
            end
            @(posedge clock);
            #1;
            if (do_en2) begin
                im_req = ~W'(n2);
                chk("dut16_re", 32'(do_re2), 32'(n2));
                chk("dut16_im", 32'(do_im2), 32'(im_req));
                chk("dut16_sof", 32'(do_sof2), 32'(n2 == 0));
                chk("dut16_eof", 32'(do_eof2), 32'(n2 == 15));
                n2++;
            end
        end
        chk("dut16_len", 32'(n2), 32'd16);
        chk("dut16_ovf", 32'(ovf2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
